// File: rtl/audio_pkg.sv
// Shared audio-path types: capture FSM states and default sample width.
package audio_pkg;
    localparam int AUDIO_WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RECORD,
        ST_FINISH
    } rec_state_t;
endpackage

// File: rtl/record_controller.sv
// Capture controller: drops the first DISCARD_WORDS deserializer words, then
// streams samples into memory until stop or memory full. All outputs registered.
module record_controller
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH   = AUDIO_WORD_LENGTH,
    parameter int ADDR_WIDTH    = 14,
    parameter int DISCARD_WORDS = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   deser_enable_o,
    input  logic                   deser_done_i,
    input  logic [WORD_LENGTH-1:0] deser_data_i,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [WORD_LENGTH-1:0] mem_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_WIDTH:0]    length_o
);
    localparam int DISC_W = $clog2(DISCARD_WORDS + 1) + 1;
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    rec_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [DISC_W-1:0]      discard_q, discard_d;
    logic                   enable_q, enable_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_LENGTH-1:0] mem_data_q, mem_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ADDR_WIDTH:0]    length_q, length_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        we_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        length_d   = length_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d    = '0;
                    count_d   = '0;
                    discard_d = '0;
                    state_d   = (DISCARD_WORDS == 0) ? ST_RECORD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop_i) begin
                    state_d = ST_FINISH;
                end else if (deser_done_i) begin
                    discard_d = discard_q + 1'b1;
                    if (discard_d == DISC_W'(DISCARD_WORDS)) state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (deser_done_i) begin
                    we_d       = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = deser_data_i;
                    count_d    = count_q + 1'b1;
                    // Hold the address on the final slot instead of wrapping.
                    if (count_d == MAX_WORDS) state_d = ST_FINISH;
                    else                      addr_d  = addr_q + 1'b1;
                end
                if (stop_i) state_d = ST_FINISH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        enable_d = (state_d == ST_SETTLE) || (state_d == ST_RECORD);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FINISH);
        if (done_d) length_d = count_d;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            enable_q   <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            length_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            enable_q   <= enable_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            length_q   <= length_d;
        end
    end

    assign deser_enable_o = enable_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign length_o       = length_q;
endmodule

// File: tb/tb_record_controller.sv
// Directed bench for record_controller with an 8-word memory and 2 settle words.
module tb_record_controller;
    localparam int WL = 16;
    localparam int AW = 3;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          deser_en;
    logic          deser_done = 1'b0;
    logic [WL-1:0] deser_data = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WL-1:0] mem_data;
    logic          busy;
    logic          done;
    logic [AW:0]   length;

    int n_chk  = 0;
    int n_pass = 0;

    record_controller #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .DISCARD_WORDS(DW)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .stop_i(stop),
        .deser_enable_o(deser_en), .deser_done_i(deser_done), .deser_data_i(deser_data),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .busy_o(busy), .done_o(done), .length_o(length)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are read on the falling edge after.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic word(input logic [WL-1:0] d, input logic with_stop);
        @(negedge clk) begin deser_done = 1'b1; deser_data = d; stop = with_stop; end
        @(negedge clk) begin deser_done = 1'b0; stop = 1'b0; end
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    initial begin
        // Reset with every input active.
        @(negedge clk) begin
            rst = 1'b1; start = 1'b1; stop = 1'b1; deser_done = 1'b1; deser_data = 16'hFFFF;
        end
        repeat (3) @(negedge clk);
        check("rst_we", 32'(mem_we), 0);
        check("rst_en", 32'(deser_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_len", 32'(length), 0);
        start = 1'b0; stop = 1'b0; deser_done = 1'b0; deser_data = '0;
        rst = 1'b0;
        idle_cycle();
        check("post_rst_busy", 32'(busy), 0);

        // Normal capture: 2 settle words, 3 recorded, then stop.
        pulse_start();
        check("t1_busy", 32'(busy), 1);
        check("t1_en", 32'(deser_en), 1);
        word(16'h0AAA, 1'b0);
        check("t1_settle0_we", 32'(mem_we), 0);
        word(16'h0BBB, 1'b0);
        check("t1_settle1_we", 32'(mem_we), 0);
        word(16'h1111, 1'b0);
        check("t1_w0_we", 32'(mem_we), 1);
        check("t1_w0_addr", 32'(mem_addr), 0);
        check("t1_w0_data", 32'(mem_data), 32'h1111);
        word(16'h2222, 1'b0);
        check("t1_w1_addr", 32'(mem_addr), 1);
        check("t1_w1_data", 32'(mem_data), 32'h2222);
        word(16'h3333, 1'b0);
        check("t1_w2_addr", 32'(mem_addr), 2);
        check("t1_w2_data", 32'(mem_data), 32'h3333);
        idle_cycle();
        check("t1_hold_we", 32'(mem_we), 0);
        check("t1_hold_addr", 32'(mem_addr), 2);
        check("t1_hold_data", 32'(mem_data), 32'h3333);
        pulse_stop();
        check("t1_done", 32'(done), 1);
        check("t1_len", 32'(length), 3);
        check("t1_fin_en", 32'(deser_en), 0);
        idle_cycle();
        check("t1_done_1cyc", 32'(done), 0);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_len_hold", 32'(length), 3);

        // Overflow: 10 words offered, only 8 stored, automatic finish.
        pulse_start();
        word(16'h0001, 1'b0);
        word(16'h0002, 1'b0);
        for (int i = 0; i < 8; i++) begin
            word(16'hC000 + 16'(i), 1'b0);
            check("t2_we", 32'(mem_we), 1);
            check("t2_addr", 32'(mem_addr), 32'(i));
            check("t2_data", 32'(mem_data), 32'hC000 + 32'(i));
        end
        check("t2_done", 32'(done), 1);
        check("t2_en_off", 32'(deser_en), 0);
        check("t2_len", 32'(length), 8);
        word(16'hDEAD, 1'b0);
        check("t2_extra_we", 32'(mem_we), 0);
        check("t2_extra_done", 32'(done), 0);
        word(16'hBEEF, 1'b0);
        check("t2_extra2_we", 32'(mem_we), 0);
        check("t2_no_wrap", 32'(mem_addr), 7);
        check("t2_len_hold", 32'(length), 8);

        // Stop coinciding with a word: the word still lands and counts.
        pulse_start();
        word(16'h0001, 1'b0);
        word(16'h0002, 1'b0);
        word(16'h5555, 1'b0);
        word(16'hABCD, 1'b1);
        check("t3_we", 32'(mem_we), 1);
        check("t3_addr", 32'(mem_addr), 1);
        check("t3_data", 32'(mem_data), 32'hABCD);
        check("t3_done", 32'(done), 1);
        check("t3_len", 32'(length), 2);
        idle_cycle();
        check("t3_busy", 32'(busy), 0);

        // Stop during settle; a start while busy is ignored.
        pulse_start();
        word(16'h0001, 1'b0);
        pulse_start();
        check("t4_busy", 32'(busy), 1);
        check("t4_en", 32'(deser_en), 1);
        pulse_stop();
        check("t4_we", 32'(mem_we), 0);
        check("t4_done", 32'(done), 1);
        check("t4_len", 32'(length), 0);
        idle_cycle();
        check("t4_idle", 32'(busy), 0);
        pulse_stop();
        check("t4_stop_idle_done", 32'(done), 0);
        check("t4_stop_idle_busy", 32'(busy), 0);

        // Reset mid-capture after 3 recorded words.
        pulse_start();
        word(16'h0001, 1'b0);
        word(16'h0002, 1'b0);
        word(16'h7001, 1'b0);
        word(16'h7002, 1'b0);
        @(negedge clk) begin deser_done = 1'b1; deser_data = 16'h7003; end
        @(negedge clk) begin deser_done = 1'b0; end
        check("t5_pre_addr", 32'(mem_addr), 2);
        #1 rst = 1'b1;
        #1;
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_en", 32'(deser_en), 0);
        check("t5_async_len", 32'(length), 0);
        check("t5_async_addr", 32'(mem_addr), 0);
        @(negedge clk) rst = 1'b0;
        idle_cycle();
        check("t5_rel_we", 32'(mem_we), 0);
        check("t5_rel_done", 32'(done), 0);
        idle_cycle();
        check("t5_rel_done2", 32'(done), 0);
        check("t5_len", 32'(length), 0);
        pulse_start();
        word(16'h0001, 1'b0);
        word(16'h0002, 1'b0);
        word(16'h9999, 1'b0);
        check("t5_restart_we", 32'(mem_we), 1);
        check("t5_restart_addr", 32'(mem_addr), 0);
        check("t5_restart_data", 32'(mem_data), 32'h9999);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        $display("FAIL timeout: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
